alu_operand_grf: RTL and testbench
==================================

Name: alu_operand_grf

Overview:
- Register-file and operand-issue stage directly upstream of the 3-bit-opcode ALU. Holds a 32-entry general register file and reads two source registers per accepted request.
- Presents registered operands A and B, plus the ALU opcode, to the ALU through a valid/ready handshake.
- The ALU result is written back through the independent write port.

Parameters:
- DATA_W, 32, register and operand width.
- ADDR_W, 5, register index width; depth = 2**ADDR_W.
- OP_W, 3, ALU opcode width; the field is passed through untouched.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  issue request valid.
- in_ready  out  1  stage can accept a request this cycle.
- rs_addr  in  ADDR_W  source index for operand A.
- rt_addr  in  ADDR_W  source index for operand B.
- op_in  in  OP_W  ALU opcode for this request.
- we  in  1  register write enable (writeback).
- wa  in  ADDR_W  write index.
- wd  in  DATA_W  write data.
- out_valid  out  1  operands valid toward ALU.
- out_ready  in  1  ALU/consumer accepts operands.
- A  out  DATA_W  operand A to ALU.
- B  out  DATA_W  operand B to ALU.
- ALUOp  out  OP_W  opcode to ALU.

Behaviour:
- Reset (async, asserted at any time, including mid-transfer):
  - all registers clear to 0;
  - out_valid = 0; A, B and ALUOp = 0;
  - in_ready = 1 once the reset deasserts.
- Register 0 is hardwired to 0:
  - writes with wa = 0 are ignored;
  - reads of index 0 always return 0.
- Write port:
  - on posedge, if we = 1 and wa != 0, reg[wa] <= wd;
  - the write port is independent of the handshake and never stalls.
- Read: combinational lookup of rs_addr and rt_addr, sampled into the output register on accept.
- Handshake:
  - in_ready = !out_valid || out_ready;
  - accept occurs when in_valid && in_ready.
  - On accept, on the next posedge: A <= read(rs_addr), B <= read(rt_addr), ALUOp <= op_in, out_valid <= 1.
  - If out_ready && out_valid && !accept, out_valid <= 0 on the next posedge.
  - While out_valid && !out_ready, A, B and ALUOp hold stable. in_ready = 0.
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 request per cycle while out_ready = 1.
- Same-cycle write and read of the same index (baseline): the read returns the pre-write value.
- Already-issued operands are never updated by later writes, even while stalled.
- Write and accept in the same cycle to different indices: independent, both take effect.
- Indices wrap naturally within ADDR_W bits; no out-of-range case exists.

Optional Feature:
- Macro: GRF_BYPASS_EN.
- Defined:
  - On accept, if we = 1, wa != 0 and wa == rs_addr, A <= wd instead of the stored value.
  - The same applies to B with rt_addr.
  - wa = 0 is never bypassed.
- Undefined: no bypass; the read returns the pre-write value as in the baseline.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W and OP_W constants;
  - ALU opcode constants: ADD=0, SUB=1, AND=2, OR=3, SRL=4, SRA=5.
- One natural sub-module, grf_core: the register array with two combinational read ports and one sync write port. It owns the zero-register rule and the bypass mux.
- The handshake and output register stay in the top level.

Test Plan:
- Reset behaviour: assert reset -> out_valid = 0, A = B = 0, ALUOp = 0. Then issue rs = 7, rt = 9 -> A = 0, B = 0.
- Write then read: write reg3 = 0x0000_00FF and reg4 = 0x8000_0000. Next cycle, issue rs = 3, rt = 4, op = 1 -> one cycle later out_valid = 1, A = 0xFF, B = 0x8000_0000, ALUOp = 1.
- Zero register: write wa = 0, wd = 0xDEAD_BEEF. Issue rs = 0 -> A = 0.
- Backpressure:
  - issue request X (A = 5) with out_ready = 0 for 3 cycles -> in_ready = 0 and A holds 5 throughout;
  - set out_ready = 1 with request Y pending -> Y appears the next cycle with no gap and no duplicate.
- Same-cycle hazard: reg5 = 1; write reg5 = 2 in the same cycle as an accept with rs = 5 -> A = 1 without GRF_BYPASS_EN, A = 2 with it. A later read returns 2 in both builds.
- Reset mid-operation: with out_valid = 1 and out_ready = 0, assert reset asynchronously -> out_valid drops immediately, not at the clock edge, and reg3 reads 0 afterwards.

Source files
------------

// File: rtl/alu_operand_grf_pkg.sv
// Shared widths and ALU opcode constants for the operand-issue stage.
// Used by alu_operand_grf and grf_core; optional feature macro: GRF_BYPASS_EN.
package alu_operand_grf_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int OP_W   = 3;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SRL = 3'd4,
      ALU_SRA = 3'd5
   } alu_op_e;

   function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
      return (idx == '0);
   endfunction

endpackage

// File: rtl/alu_operand_grf_core.sv
// grf_core: 32-entry register array, two combinational read ports, one write port.
// Register 0 reads as zero; GRF_BYPASS_EN forwards same-cycle write data to the reads.
module grf_core
   import alu_operand_grf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra,
   input  logic [ADDR_W-1:0] rb,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_live;

   assign wr_live = we && !is_zero_idx(wa);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_live) begin
         regs[wa] <= wd;
      end
   end

   always_comb begin
      rd_a = is_zero_idx(ra) ? '0 : regs[ra];
      rd_b = is_zero_idx(rb) ? '0 : regs[rb];
`ifdef GRF_BYPASS_EN
      // wr_live already excludes index 0, so the zero register is never forwarded
      if (wr_live && (wa == ra)) rd_a = wd;
      if (wr_live && (wa == rb)) rd_b = wd;
`endif
   end

endmodule

// File: rtl/alu_operand_grf.sv
// Operand-issue stage: reads two registers on accept and holds them for the ALU
// behind a valid/ready handshake. Optional same-cycle bypass: GRF_BYPASS_EN.
module alu_operand_grf
   import alu_operand_grf_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [OP_W-1:0]   op_in,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic [OP_W-1:0]   ALUOp
);

   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic              accept;

   grf_core u_grf_core (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .wa    (wa),
      .wd    (wd),
      .ra    (rs_addr),
      .rb    (rt_addr),
      .rd_a  (rd_a),
      .rd_b  (rd_b)
   );

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Operands are captured once; later writes never touch an issued pair.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         A         <= '0;
         B         <= '0;
         ALUOp     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         A         <= rd_a;
         B         <= rd_b;
         ALUOp     <= op_in;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_operand_grf.sv
// Self-checking bench for alu_operand_grf: directed steps plus random traffic
// against a behavioural model; expectations follow GRF_BYPASS_EN when defined.
module tb_alu_operand_grf;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [2:0]  op_in;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [2:0]  ALUOp;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [32];
   logic        m_valid;
   logic [31:0] m_a;
   logic [31:0] m_b;
   logic [2:0]  m_op;

   alu_operand_grf dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .op_in     (op_in),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .B         (B),
      .ALUOp     (ALUOp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef GRF_BYPASS_EN
      if (we && wa == idx) return wd;
`endif
      return m_regs[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_valid = 1'b0;
      m_a = 32'd0;
      m_b = 32'd0;
      m_op = 3'd0;
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic step();
      logic        rdy;
      logic        acc;
      logic [31:0] ra;
      logic [31:0] rb;
      #1;
      rdy = !m_valid || out_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      acc = in_valid && rdy;
      ra = model_read(rs_addr);
      rb = model_read(rt_addr);
      @(posedge clk);
      #1;
      if (acc) begin
         m_valid = 1'b1;
         m_a = ra;
         m_b = rb;
         m_op = op_in;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
      if (we && wa != 5'd0) m_regs[wa] = wd;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("A", A, m_a);
      chk("B", B, m_b);
      chk("ALUOp", {29'd0, ALUOp}, {29'd0, m_op});
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      op_in = 3'd0;
      we = 1'b0;
      wa = 5'd0;
      wd = 32'd0;
      out_ready = 1'b1;
   endtask

   initial begin
      idle_inputs();
      model_reset();

      // reset state
      reset = 1'b1;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_A", A, 32'd0);
      chk("rst_B", B, 32'd0);
      chk("rst_ALUOp", {29'd0, ALUOp}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // read of cleared registers
      in_valid = 1'b1; rs_addr = 5'd7; rt_addr = 5'd9; op_in = 3'd0;
      step();
      chk("clr_A", A, 32'd0);
      chk("clr_B", B, 32'd0);
      in_valid = 1'b0;
      step();

      // write then read
      we = 1'b1; wa = 5'd3; wd = 32'h0000_00FF;
      step();
      wa = 5'd4; wd = 32'h8000_0000;
      step();
      we = 1'b0;
      in_valid = 1'b1; rs_addr = 5'd3; rt_addr = 5'd4; op_in = 3'd1;
      step();
      chk("wr_out_valid", {31'd0, out_valid}, 32'd1);
      chk("wr_A", A, 32'h0000_00FF);
      chk("wr_B", B, 32'h8000_0000);
      chk("wr_ALUOp", {29'd0, ALUOp}, 32'd1);
      in_valid = 1'b0;
      step();

      // zero register ignores writes
      we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF;
      step();
      we = 1'b0;
      in_valid = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0;
      step();
      chk("zero_A", A, 32'd0);
      in_valid = 1'b0;

      // backpressure: X holds while stalled, Y follows with no gap
      we = 1'b1; wa = 5'd6; wd = 32'd5;
      step();
      we = 1'b0;
      in_valid = 1'b1; rs_addr = 5'd6; rt_addr = 5'd3; op_in = 3'd2; out_ready = 1'b0;
      step();
      rs_addr = 5'd4; rt_addr = 5'd3; op_in = 3'd3;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         step();
         chk("bp_hold_A", A, 32'd5);
      end
      out_ready = 1'b1;
      step();
      chk("bp_y_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_y_A", A, 32'h8000_0000);
      chk("bp_y_op", {29'd0, ALUOp}, 32'd3);
      in_valid = 1'b0;
      step();
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);

      // same-cycle write/read hazard
      we = 1'b1; wa = 5'd5; wd = 32'd1;
      step();
      wd = 32'd2; in_valid = 1'b1; rs_addr = 5'd5; rt_addr = 5'd0;
      step();
`ifdef GRF_BYPASS_EN
      chk("hz_A", A, 32'd2);
`else
      chk("hz_A", A, 32'd1);
`endif
      we = 1'b0;
      step();
      chk("hz_later_A", A, 32'd2);
      in_valid = 1'b0;
      step();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         in_valid = 1'($urandom_range(0, 3) != 0);
         out_ready = 1'($urandom_range(0, 2) != 0);
         rs_addr = 5'($urandom);
         rt_addr = 5'($urandom);
         op_in = 3'($urandom_range(0, 5));
         we = 1'($urandom);
         wa = 5'($urandom);
         wd = $urandom;
         step();
      end

      // asynchronous reset mid-transfer
      idle_inputs();
      we = 1'b1; wa = 5'd3; wd = 32'h1234_5678;
      step();
      we = 1'b0; in_valid = 1'b1; rs_addr = 5'd3; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk("mid_pre_valid", {31'd0, out_valid}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_async_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_async_A", A, 32'd0);
      idle_inputs();
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1; rs_addr = 5'd3; rt_addr = 5'd3;
      step();
      chk("mid_reg3_cleared", A, 32'd0);
      in_valid = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
